// File: rtl/imm_extend_pipe.sv
// Immediate extractor/extender for 32-bit instruction words, with a 2-entry
// in-order output FIFO and a saturating count of words that could not be decoded.
module imm_extend_pipe #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BR_SHIFT = 0
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic [31:0]       Instr32,
  input  logic              InValid,
  output logic              InReady,
  output logic [DATA_W-1:0] BusImm,
  output logic              ImmErr,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [7:0]        ErrCount
);

  localparam int unsigned N_ENT = 2;

  typedef enum logic [2:0] {
    FMT_B,
    FMT_CB,
    FMT_D,
    FMT_I,
    FMT_IW,
    FMT_BAD
  } fmt_e;

  fmt_e              fmt;
  logic [DATA_W-1:0] b_ext;
  logic [DATA_W-1:0] cb_ext;
  logic [DATA_W-1:0] d_ext;
  logic [DATA_W-1:0] i_ext;
  logic [DATA_W-1:0] iw_ext;
  logic [DATA_W-1:0] b_imm;
  logic [DATA_W-1:0] cb_imm;
  logic [5:0]        iw_sh;
  logic              iw_bad;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_err;

  // Opcode classification, first match wins in B, CB, D, I, IW order.
  always_comb begin
    fmt = FMT_BAD;
    if (Instr32[31:26] == 6'b000101) begin
      fmt = FMT_B;
    end else if ((Instr32[31:24] == 8'b10110100) || (Instr32[31:24] == 8'b10110101) ||
                 (Instr32[31:24] == 8'b01010100)) begin
      fmt = FMT_CB;
    end else if ((Instr32[31:21] == 11'b11111000010) || (Instr32[31:21] == 11'b11111000000)) begin
      fmt = FMT_D;
    end else if ((Instr32[31:22] == 10'b1001000100) || (Instr32[31:22] == 10'b1101000100)) begin
      fmt = FMT_I;
    end else if (Instr32[31:23] == 9'b110100101) begin
      fmt = FMT_IW;
    end
  end

  assign b_ext  = {{(DATA_W-26){Instr32[25]}}, Instr32[25:0]};
  assign cb_ext = {{(DATA_W-19){Instr32[23]}}, Instr32[23:5]};
  assign d_ext  = {{(DATA_W-9){Instr32[20]}}, Instr32[20:12]};
  assign i_ext  = {{(DATA_W-12){1'b0}}, Instr32[21:10]};
  assign iw_sh  = {Instr32[22:21], 4'b0000};
  assign iw_ext = {{(DATA_W-16){1'b0}}, Instr32[20:5]} << iw_sh;
  // A 32-bit result cannot hold a halfword placed at bit 32 or 48.
  assign iw_bad = (DATA_W == 32) && Instr32[22];

  generate
    if (BR_SHIFT != 0) begin : g_br_shift
      assign b_imm  = {b_ext[DATA_W-3:0], 2'b00};
      assign cb_imm = {cb_ext[DATA_W-3:0], 2'b00};
    end else begin : g_br_plain
      assign b_imm  = b_ext;
      assign cb_imm = cb_ext;
    end
  endgenerate

  always_comb begin
    dec_imm = '0;
    dec_err = 1'b0;
    case (fmt)
      FMT_B:   dec_imm = b_imm;
      FMT_CB:  dec_imm = cb_imm;
      FMT_D:   dec_imm = d_ext;
      FMT_I:   dec_imm = i_ext;
      FMT_IW: begin
        if (iw_bad) begin
          dec_err = 1'b1;
        end else begin
          dec_imm = iw_ext;
        end
      end
      default: dec_err = 1'b1;
    endcase
  end

  logic [DATA_W-1:0] imm_mem_q [N_ENT];
  logic [DATA_W-1:0] imm_mem_d [N_ENT];
  logic              err_mem_q [N_ENT];
  logic              err_mem_d [N_ENT];
  logic              rd_ptr_q;
  logic              rd_ptr_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic [7:0]        err_cnt_q;
  logic [7:0]        err_cnt_d;
  logic              push;
  logic              pop;
  logic              wr_ptr;

  assign push = InValid && in_ready_q;
  assign pop  = (count_q != 2'd0) && OutReady;
  // Write slot sits just past the occupied ones; with one entry held it is the other slot.
  assign wr_ptr = rd_ptr_q ^ (count_q == 2'd1);

  always_comb begin
    imm_mem_d = imm_mem_q;
    err_mem_d = err_mem_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q + {1'b0, push} - {1'b0, pop};
    err_cnt_d = err_cnt_q;
    if (push) begin
      imm_mem_d[wr_ptr] = dec_imm;
      err_mem_d[wr_ptr] = dec_err;
      if (dec_err && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // Ready is registered from the next occupancy so it never depends on inputs.
    in_ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < N_ENT; i++) begin
        imm_mem_q[i] <= '0;
        err_mem_q[i] <= 1'b0;
      end
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      err_cnt_q  <= 8'd0;
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        imm_mem_q[i] <= imm_mem_d[i];
        err_mem_q[i] <= err_mem_d[i];
      end
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign InReady  = in_ready_q;
  assign OutValid = (count_q != 2'd0);
  assign BusImm   = OutValid ? imm_mem_q[rd_ptr_q] : '0;
  assign ImmErr   = OutValid && err_mem_q[rd_ptr_q];
  assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench: two instances (64-bit unshifted, 32-bit branch-shifted) share
// stimulus; a reference model fills per-instance queues that a negedge monitor drains.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready64, imm_err64, out_valid64;
  logic [63:0] bus64;
  logic [7:0]  ecnt64;
  logic        in_ready32, imm_err32, out_valid32;
  logic [31:0] bus32;
  logic [7:0]  ecnt32;

  imm_extend_pipe #(.DATA_W(64), .BR_SHIFT(0)) dut64 (
    .CLK(clk), .RESETn(rst_n), .Instr32(instr), .InValid(in_valid), .InReady(in_ready64),
    .BusImm(bus64), .ImmErr(imm_err64), .OutValid(out_valid64), .OutReady(out_ready),
    .ErrCount(ecnt64)
  );

  imm_extend_pipe #(.DATA_W(32), .BR_SHIFT(1)) dut32 (
    .CLK(clk), .RESETn(rst_n), .Instr32(instr), .InValid(in_valid), .InReady(in_ready32),
    .BusImm(bus32), .ImmErr(imm_err32), .OutValid(out_valid32), .OutReady(out_ready),
    .ErrCount(ecnt32)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  exp_t sb64[$];
  exp_t sb32[$];
  int   n_vec = 0;
  int   n_fail = 0;
  int   mdl_ecnt64 = 0;
  int   mdl_ecnt32 = 0;
  int   edges;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else if (edges < 4) edges <= edges + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: decode straight from the opcode table using integer arithmetic.
  function automatic void ref_model(input logic [31:0] w, input int dw, input bit brs,
                                    output logic [63:0] imm, output logic err);
    longint v;
    int     hw;
    v   = 0;
    err = 1'b0;
    if (w[31:26] == 6'b000101) begin
      v = longint'($signed(w[25:0]));
      if (brs) v = v * 4;
    end else if (w[31:24] == 8'hB4 || w[31:24] == 8'hB5 || w[31:24] == 8'h54) begin
      v = longint'($signed(w[23:5]));
      if (brs) v = v * 4;
    end else if (w[31:21] == 11'b11111000010 || w[31:21] == 11'b11111000000) begin
      v = longint'($signed(w[20:12]));
    end else if (w[31:22] == 10'b1001000100 || w[31:22] == 10'b1101000100) begin
      v = longint'(w[21:10]);
    end else if (w[31:23] == 9'b110100101) begin
      hw = int'(w[22:21]);
      if (dw == 32 && hw >= 2) err = 1'b1;
      else v = longint'(w[20:5]) * (longint'(1) << (16 * hw));
    end else begin
      err = 1'b1;
    end
    if (dw == 32) imm = {32'h0, v[31:0]};
    else imm = v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 7))
      0: w[31:26] = 6'b000101;
      1: w[31:24] = 8'hB4;
      2: w[31:24] = ($urandom_range(0, 1) != 0) ? 8'hB5 : 8'h54;
      3: w[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
      4: w[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
      5: w[31:23] = 9'b110100101;
      6: w = 32'h0;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: checks flow control and ErrCount every cycle, pops on output transfer,
  // and pushes the model's answer for each word that will be accepted at the next edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] imm;
    logic        err;
    if (rst_n === 1'b1) begin
      chk("in_ready64", 64'(in_ready64), 64'((edges > 0) && (sb64.size() < 2)));
      chk("in_ready32", 64'(in_ready32), 64'((edges > 0) && (sb32.size() < 2)));
      chk("out_valid64", 64'(out_valid64), 64'(sb64.size() != 0));
      chk("out_valid32", 64'(out_valid32), 64'(sb32.size() != 0));
      chk("err_count64", 64'(ecnt64), 64'(mdl_ecnt64));
      chk("err_count32", 64'(ecnt32), 64'(mdl_ecnt32));
      if (out_valid64 && out_ready && sb64.size() != 0) begin
        e = sb64.pop_front();
        chk("bus_imm64", bus64, e.imm);
        chk("imm_err64", 64'(imm_err64), 64'(e.err));
      end
      if (out_valid32 && out_ready && sb32.size() != 0) begin
        e = sb32.pop_front();
        chk("bus_imm32", 64'(bus32), e.imm);
        chk("imm_err32", 64'(imm_err32), 64'(e.err));
      end
      if (in_valid && in_ready64) begin
        ref_model(instr, 64, 1'b0, imm, err);
        e.imm = imm;
        e.err = err;
        sb64.push_back(e);
        if (err && mdl_ecnt64 < 255) mdl_ecnt64++;
      end
      if (in_valid && in_ready32) begin
        ref_model(instr, 32, 1'b1, imm, err);
        e.imm = imm;
        e.err = err;
        sb32.push_back(e);
        if (err && mdl_ecnt32 < 255) mdl_ecnt32++;
      end
    end
  end

  task automatic clear_model();
    sb64.delete();
    sb32.delete();
    mdl_ecnt64 = 0;
    mdl_ecnt32 = 0;
  endtask

  // Called at a non-edge time; returns 1 time unit after the accepting edge.
  task automatic send(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    instr = w;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready64;
    end
    if (!ok) begin
      n_vec++;
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b, expected 1 within 64 cycles", in_ready64);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic directed(input string name, input logic [31:0] w,
                          input logic [63:0] e64, input logic e64err,
                          input logic [31:0] e32, input logic e32err);
    out_ready = 1'b1;
    send(w);
    @(negedge clk);
    chk({name, "_valid64"}, 64'(out_valid64), 64'(1));
    chk({name, "_imm64"}, bus64, e64);
    chk({name, "_err64"}, 64'(imm_err64), 64'(e64err));
    chk({name, "_valid32"}, 64'(out_valid32), 64'(1));
    chk({name, "_imm32"}, 64'(bus32), 64'(e32));
    chk({name, "_err32"}, 64'(imm_err32), 64'(e32err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    instr = 32'h0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'({in_ready64, in_ready32}), 64'(0));
    chk("rst_out_valid", 64'({out_valid64, out_valid32}), 64'(0));
    chk("rst_bus64", bus64, 64'(0));
    chk("rst_bus32", 64'(bus32), 64'(0));
    chk("rst_imm_err", 64'({imm_err64, imm_err32}), 64'(0));
    chk("rst_err_count", 64'({ecnt64, ecnt32}), 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Error count starts fresh: the 32-bit MOVZ hw=2 is its first error.
    directed("b_m1", {6'b000101, 26'h3FF_FFFF}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 1'b0);
    directed("movz_hw2", {9'b110100101, 2'b10, 16'hABCD, 5'd3}, 64'h0000_ABCD_0000_0000, 1'b0,
             32'h0, 1'b1);
    chk("errcnt32_first", 64'(ecnt32), 64'(1));
    chk("errcnt64_first", 64'(ecnt64), 64'(0));
    directed("b_5", {6'b000101, 26'd5}, 64'd5, 1'b0, 32'h14, 1'b0);
    directed("b_m14", {6'b000101, 26'h3FF_FFF2}, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0, 32'hFFFF_FFC8, 1'b0);
    directed("ldur_m9", {11'b11111000010, 9'h1F7, 2'b00, 10'h0}, 64'hFFFF_FFFF_FFFF_FFF7, 1'b0,
             32'hFFFF_FFF7, 1'b0);
    directed("cbz_m3", {8'hB4, 19'h7_FFFD, 5'h0}, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 32'hFFFF_FFF4, 1'b0);
    directed("movz_hw3", {9'b110100101, 2'b11, 16'h1234, 5'h0}, 64'h1234_0000_0000_0000, 1'b0,
             32'h0, 1'b1);
    directed("addi_fff", {10'b1001000100, 12'hFFF, 10'h0}, 64'h0FFF, 1'b0, 32'h0FFF, 1'b0);

    // Backpressure: two words fill the buffer, the third waits while its data wanders.
    out_ready = 1'b0;
    send({6'b000101, 26'd1});
    send({10'b1101000100, 12'h0AB, 10'h155});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready64", 64'(in_ready64), 64'(0));
      chk("bp_in_ready32", 64'(in_ready32), 64'(0));
      @(posedge clk);
      #1;
      instr = $urandom;
    end
    out_ready = 1'b1;
    send({8'h54, 19'h4_0000, 5'h0});
    repeat (4) @(posedge clk);
    #1;
    chk("bp_drained64", 64'(sb64.size()), 64'(0));
    chk("bp_drained32", 64'(sb32.size()), 64'(0));

    // Random traffic with random backpressure.
    for (int c = 0; c < 2000; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      instr = gen_instr();
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drained64", 64'(sb64.size()), 64'(0));

    // Error counter saturation from a fresh reset.
    rst_n = 1'b0;
    clear_model();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    acc = 0;
    in_valid = 1'b1;
    instr = 32'h0;
    for (int k = 0; k < 400 && acc < 300; k++) begin
      @(negedge clk);
      if (in_ready64) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("sat_accepted", 64'(acc), 64'(300));
    @(negedge clk);
    chk("sat_count64", 64'(ecnt64), 64'(255));
    chk("sat_count32", 64'(ecnt32), 64'(255));
    @(posedge clk);
    #1;

    // Reset with two entries held.
    out_ready = 1'b0;
    send(32'h0);
    send({6'b000101, 26'd7});
    @(negedge clk);
    chk("pre_rst_valid64", 64'(out_valid64), 64'(1));
    chk("pre_rst_ready64", 64'(in_ready64), 64'(0));
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    chk("mid_rst_valid", 64'({out_valid64, out_valid32}), 64'(0));
    chk("mid_rst_count64", 64'(ecnt64), 64'(0));
    chk("mid_rst_count32", 64'(ecnt32), 64'(0));
    chk("mid_rst_ready", 64'({in_ready64, in_ready32}), 64'(0));
    chk("mid_rst_bus64", bus64, 64'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    directed("post_rst", {10'b1001000100, 12'h123, 10'h0}, 64'h123, 1'b0, 32'h123, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_empty64", 64'(sb64.size()), 64'(0));
    chk("final_empty32", 64'(sb32.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
